// File: rtl/tutorial_ctrl_unit.sv
// Microsequencer for the 8-bit tutorial datapath: expands {op, imm} into one or two
// register-transfer steps. Define CTRL_BACK_TO_BACK_EN to accept the next instruction during the last step.
module tutorial_ctrl_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [IMM_W+1:0]   instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               done,
  output logic               dp_clear,
  output logic [DATA_W-1:0]  AddImmediate,
  output logic [DATA_W-1:0]  RegisterAimmediate,
  output logic               RAout,
  output logic               RBout,
  output logic               RZout,
  output logic               RAin,
  output logic               RBin,
  output logic               RZin
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    T1   = 2'd2,
    T2   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [IMM_W-1:0]   imm_q, imm_d;

  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               dpclr_q, dpclr_d;
  logic [DATA_W-1:0]  add_imm_q, add_imm_d;
  logic [DATA_W-1:0]  rega_imm_q, rega_imm_d;
  logic               ra_out_q, ra_out_d;
  logic               rb_out_q, rb_out_d;
  logic               rz_out_q, rz_out_d;
  logic               ra_in_q, ra_in_d;
  logic               rb_in_q, rb_in_d;
  logic               rz_in_q, rz_in_d;

  logic               accept;
  logic               last_step_q;
  logic               last_step_d;
  logic [DATA_W-1:0]  imm_ext_d;

  // The handshake uses the registered ready, so instr/instr_valid never reach an output combinationally.
  assign accept      = instr_valid & ready_q;
  assign last_step_q = ((state_q == T1) && !op_q[1]) || (state_q == T2);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    unique case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (accept) begin
          state_d = T1;
          op_d    = instr[IMM_W+1:IMM_W];
          imm_d   = instr[IMM_W-1:0];
        end
      end
      T1, T2: begin
        if (!last_step_q) begin
          state_d = T2;
        end else if (accept) begin
          state_d = T1;
          op_d    = instr[IMM_W+1:IMM_W];
          imm_d   = instr[IMM_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the step they belong to.
  assign last_step_d = ((state_d == T1) && !op_d[1]) || (state_d == T2);
  assign imm_ext_d   = DATA_W'(imm_d);

  always_comb begin
    add_imm_d  = '0;
    rega_imm_d = '0;
    ra_out_d   = 1'b0;
    rb_out_d   = 1'b0;
    rz_out_d   = 1'b0;
    ra_in_d    = 1'b0;
    rb_in_d    = 1'b0;
    rz_in_d    = 1'b0;
    if (state_d == T1) begin
      unique case (op_d)
        2'b00: ;
        2'b01: begin
          rega_imm_d = imm_ext_d;
          ra_in_d    = 1'b1;
        end
        default: begin
          ra_out_d  = 1'b1;
          add_imm_d = imm_ext_d;
          rz_in_d   = 1'b1;
        end
      endcase
    end else if (state_d == T2) begin
      rz_out_d = 1'b1;
      ra_in_d  = op_d[0];
      rb_in_d  = !op_d[0];
    end
  end

  always_comb begin
`ifdef CTRL_BACK_TO_BACK_EN
    ready_d = (state_d == IDLE) || last_step_d;
`else
    ready_d = (state_d == IDLE);
`endif
    done_d  = last_step_q;
    dpclr_d = (state_d == INIT);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= INIT;
      op_q       <= '0;
      imm_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      dpclr_q    <= 1'b1;
      add_imm_q  <= '0;
      rega_imm_q <= '0;
      ra_out_q   <= 1'b0;
      rb_out_q   <= 1'b0;
      rz_out_q   <= 1'b0;
      ra_in_q    <= 1'b0;
      rb_in_q    <= 1'b0;
      rz_in_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      dpclr_q    <= dpclr_d;
      add_imm_q  <= add_imm_d;
      rega_imm_q <= rega_imm_d;
      ra_out_q   <= ra_out_d;
      rb_out_q   <= rb_out_d;
      rz_out_q   <= rz_out_d;
      ra_in_q    <= ra_in_d;
      rb_in_q    <= rb_in_d;
      rz_in_q    <= rz_in_d;
    end
  end

  assign instr_ready        = ready_q;
  assign done               = done_q;
  assign dp_clear           = dpclr_q;
  assign AddImmediate       = add_imm_q;
  assign RegisterAimmediate = rega_imm_q;
  assign RAout              = ra_out_q;
  assign RBout              = rb_out_q;
  assign RZout              = rz_out_q;
  assign RAin               = ra_in_q;
  assign RBin               = rb_in_q;
  assign RZin               = rz_in_q;

endmodule

// File: tb/tb_tutorial_ctrl_unit.sv
// Scoreboard bench for tutorial_ctrl_unit: per-cycle expected outputs from the opcode table,
// plus a tiny datapath driven by the DUT's enables and checked against instruction-level A/B results.
module tb_tutorial_ctrl_unit;

`ifdef CTRL_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [9:0]  instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, done, dp_clear;
  logic [31:0] AddImmediate, RegisterAimmediate;
  logic        RAout, RBout, RZout, RAin, RBin, RZin;

  tutorial_ctrl_unit #(.DATA_W(32), .IMM_W(8)) dut (
    .clock(clock), .clear(clear), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .dp_clear(dp_clear),
    .AddImmediate(AddImmediate), .RegisterAimmediate(RegisterAimmediate),
    .RAout(RAout), .RBout(RBout), .RZout(RZout),
    .RAin(RAin), .RBin(RBin), .RZin(RZin)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        last;
    logic        ra_o, rb_o, rz_o, ra_i, rb_i, rz_i;
    logic [31:0] addimm;
    logic [31:0] regimm;
  } step_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  step_t       steps[$];
  logic [63:0] arch_q[$];
  logic [31:0] ref_A = '0, ref_B = '0;
  logic [31:0] dp_A = '0, dp_B = '0, dp_Z = '0;
  bit          done_pend = 1'b0;
  int unsigned post = 0;

  localparam logic [72:0] RESET_V = {3'b001, 70'b0};

  function automatic logic [72:0] actual_vec();
    return {instr_ready, done, dp_clear, RAout, RBout, RZout, RAin, RBin, RZin,
            AddImmediate, RegisterAimmediate};
  endfunction

  // Monitor: one expected step popped per cycle; empty queue means the controller should be idle.
  always @(negedge clock) begin : monitor
    step_t       s;
    logic [72:0] exp_v, act_v;
    logic [31:0] bus, nA, nB, nZ;
    bit          busy, chk_done;
    s = '0;
    busy = 1'b0;
    chk_done = 1'b0;
    act_v = actual_vec();
    if (!clear || post == 0) begin
      exp_v = RESET_V;
      if (!clear) begin
        steps.delete();
        arch_q.delete();
        post = 0;
      end else begin
        post = 1;
      end
      done_pend = 1'b0;
    end else begin
      if (steps.size() > 0) begin
        s = steps.pop_front();
        busy = 1'b1;
      end
      exp_v = {(busy ? (B2B && s.last) : 1'b1), done_pend, 1'b0,
               s.ra_o, s.rb_o, s.rz_o, s.ra_i, s.rb_i, s.rz_i, s.addimm, s.regimm};
      chk_done = done_pend;
      done_pend = busy && s.last;
    end
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle t=%0t got=%h exp=%h", $time, act_v, exp_v);
    end
    if (chk_done) begin
      checks++;
      if (arch_q.size() == 0) begin
        errors++;
        $display("FAIL arch t=%0t got done with no instruction pending", $time);
      end else begin
        logic [63:0] e;
        e = arch_q.pop_front();
        if ({dp_A, dp_B} !== e) begin
          errors++;
          $display("FAIL arch t=%0t got A=%h B=%h exp A=%h B=%h", $time, dp_A, dp_B, e[63:32], e[31:0]);
        end
      end
    end
    if (dp_clear) begin
      dp_A = '0; dp_B = '0; dp_Z = '0;
    end else begin
      bus = RAout ? dp_A : RBout ? dp_B : RZout ? dp_Z : '0;
      nA = dp_A; nB = dp_B; nZ = dp_Z;
      if (RZin) nZ = bus + AddImmediate;
      if (RAin) nA = (RAout | RBout | RZout) ? bus : RegisterAimmediate;
      if (RBin) nB = bus;
      dp_A = nA; dp_B = nB; dp_Z = nZ;
    end
  end

  task automatic push_expect(input logic [1:0] op, input logic [7:0] imm);
    step_t a, b;
    logic [31:0] ie;
    ie = {24'b0, imm};
    a = '0;
    b = '0;
    case (op)
      2'd0: a.last = 1'b1;
      2'd1: begin a.regimm = ie; a.ra_i = 1'b1; a.last = 1'b1; ref_A = ie; end
      2'd2: begin
        a.ra_o = 1'b1; a.addimm = ie; a.rz_i = 1'b1;
        b.rz_o = 1'b1; b.rb_i = 1'b1; b.last = 1'b1;
        ref_B = ref_A + ie;
      end
      default: begin
        a.ra_o = 1'b1; a.addimm = ie; a.rz_i = 1'b1;
        b.rz_o = 1'b1; b.ra_i = 1'b1; b.last = 1'b1;
        ref_A = ref_A + ie;
      end
    endcase
    steps.push_back(a);
    if (op[1]) steps.push_back(b);
    arch_q.push_back({ref_A, ref_B});
  endtask

  // Returns just before the accepting edge, with valid still asserted for that edge.
  task automatic send(input logic [1:0] op, input logic [7:0] imm, input int unsigned gap, input bit noisy);
    int unsigned n;
    bit acc;
    repeat (gap) begin
      @(negedge clock); #1;
      instr_valid = 1'b0;
      instr = 10'($urandom);
    end
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clock); #1;
      if (instr_ready) begin
        instr_valid = 1'b1;
        instr = {op, imm};
        push_expect(op, imm);
        acc = 1'b1;
      end else begin
        instr_valid = noisy ? 1'($urandom) : 1'b1;
        instr = noisy ? 10'($urandom) : {op, imm};
        n++;
        if (n > 20) begin
          checks++;
          errors++;
          $display("FAIL ready_timeout t=%0t got ready=0 exp ready=1 within 20 cycles", $time);
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clock); #1;
      instr_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(posedge clock); #2;
    clear = 1'b0;
    instr_valid = 1'b1;
    instr = 10'($urandom);
    ref_A = '0;
    ref_B = '0;
    repeat (cycles) @(posedge clock);
    #1 clear = 1'b1;
  endtask

  initial begin : driver
    logic [31:0] prev_B;
    logic [72:0] av;
    #1 clear = 1'b0;
    instr_valid = 1'b1;
    instr = 10'h3FF;
    repeat (3) @(posedge clock);
    #1 clear = 1'b1;

    send(2'd1, 8'h05, 0, 1'b0);
    send(2'd2, 8'h05, 1, 1'b0);
    send(2'd1, 8'h01, 1, 1'b0);
    send(2'd3, 8'hFF, 1, 1'b0);

    // Abort an ADDI B during its second step.
    send(2'd1, 8'h07, 1, 1'b0);
    prev_B = ref_B;
    send(2'd2, 8'h03, 1, 1'b0);
    @(posedge clock);
    #1 instr_valid = 1'b0;
    @(posedge clock);
    #2 clear = 1'b0;
    ref_A = '0;
    ref_B = '0;
    #1;
    av = actual_vec();
    checks++;
    if (av !== RESET_V) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", av, RESET_V);
    end
    checks++;
    if (dp_B !== prev_B) begin
      errors++;
      $display("FAIL abort_B got=%h exp=%h", dp_B, prev_B);
    end
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;

    send(2'd1, 8'h03, 1, 1'b0);
    send(2'd2, 8'h02, 0, 1'b0);
    send(2'd0, 8'h00, 0, 1'b0);
    idle(3);

    repeat (80) begin
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
      send(2'($urandom), 8'($urandom), $urandom_range(0, 2), 1'b1);
    end
    send(2'd3, 8'hFF, 0, 1'b1);
    idle(5);

    checks++;
    if (steps.size() != 0) begin
      errors++;
      $display("FAIL drain_steps got=%0d exp=0", steps.size());
    end
    checks++;
    if (arch_q.size() != 0) begin
      errors++;
      $display("FAIL drain_arch got=%0d exp=0", arch_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tutorial_ctrl_unit.md
# tutorial_ctrl_unit

Microsequencer for the 8-bit tutorial datapath (registers A, B, Z, shared bus, immediate adder). It accepts a short instruction word over a valid/ready handshake. It expands each instruction into one or two register-transfer steps by driving the datapath's out/in enables and immediate buses. It also generates the datapath's initialisation clear. It sits between the bench or fetch logic and the datapath instance, replacing hand-timed control stimulus.

## Interface
- DATA_W, 32, width of AddImmediate / RegisterAimmediate buses
- IMM_W, 8, immediate field width; zero-extended to DATA_W
- clock  in  1  system clock, all state on rising edge
- clear  in  1  asynchronous, active-low reset
- instr  in  IMM_W+2  {op[1:0], imm[IMM_W-1:0]}
- instr_valid  in  1  instr presented
- instr_ready  out  1  controller can accept instr this cycle
- done  out  1  one-cycle pulse: previous instruction's last step completed
- dp_clear  out  1  clear to datapath registers
- AddImmediate  out  DATA_W  immediate operand to adder
- RegisterAimmediate  out  DATA_W  immediate load value for A
- RAout, RBout, RZout  out  1 each  bus drive enables
- RAin, RBin, RZin  out  1 each  register load enables

## Operation
- States: INIT, IDLE, T1, T2. Reset (clear=0) forces INIT immediately and asynchronously. All outputs are 0 except dp_clear=1.
- INIT: dp_clear=1 for exactly one cycle after clear deasserts, then IDLE.
- IDLE: instr_ready=1, all enables 0. On instr_valid&instr_ready, latch op and imm (zero-extended) and go to T1.
- Opcodes:
  - 00 NOP: T1 drives nothing.
  - 01 LDI A,imm: T1: RegisterAimmediate=imm, RAin=1.
  - 10 ADDI B,A,imm: T1: RAout=1, AddImmediate=imm, RZin=1. T2: RZout=1, RBin=1.
  - 11 ADDI A,A,imm: T1 as op 10. T2: RZout=1, RAin=1.
- Transitions: T1 goes to T2 for op[1]=1, else to IDLE. T2 goes to IDLE.
- Immediate buses hold 0 in every cycle in which they are not used.
- Invariants:
  - At most one of RAout/RBout/RZout is high per cycle.
  - No X on outputs after reset.
- done: registered. High for one cycle, the cycle after the last step (T1 for ops 00/01, T2 for ops 1x).
- Arithmetic is performed in the datapath. The controller never modifies imm beyond zero-extension; imm=8'hFF yields 32'h000000FF.

## Timing
- All outputs are registered and decoded from state plus the latched instr. No combinational path from instr/instr_valid to any output.
- Accept at edge k, giving T1 outputs during cycle k+1 and, for ops 1x, T2 during k+2.
- Base build, ops 0x: instr_ready=0 from k+1. Back to 1 with done=1 in k+2.
- Base build, ops 1x: instr_ready=0 from k+1. Back to 1 with done=1 in k+3.
- instr_valid while instr_ready=0: ignored. The source must hold it. No sampling.
- instr changes while not accepted: no effect.
- Reset mid-T1/T2: the step is aborted, no done is produced, and INIT/dp_clear follows release.
- clear released with instr_valid=1: not accepted until IDLE, i.e. the second cycle after release.

## Configuration
- CTRL_BACK_TO_BACK_EN defined:
  - instr_ready is also 1 during the last step (T1 of ops 0x, T2 of ops 1x).
  - An instruction accepted there enters its T1 on the next cycle, with no IDLE bubble.
  - done still pulses in that next cycle, overlapping the new T1.
- Not defined: instr_ready is 1 only in IDLE, and each instruction costs one extra IDLE cycle.

## Test plan
- Reset: hold clear=0 with instr_valid=1. Required: all enables 0, dp_clear=1, instr_ready=0. After release: dp_clear=1 for one cycle, then instr_ready=1.
- LDI A,5 ({01,8'h05}): RegisterAimmediate=32'h5 and RAin=1 for exactly one cycle, other outputs 0. done one cycle later. Datapath A=5.
- Then ADDI B,A,5 ({10,8'h05}): cycle 1 RAout=1, RZin=1, AddImmediate=32'h5. Cycle 2 RZout=1, RBin=1. Then done. Datapath B=10, Z=10.
- ADDI A,A,8'hFF after A=1: AddImmediate=32'h000000FF. A=32'h100 after T2. RBin never asserted.
- Assert clear=0 during T2 of an ADDI B. Required: outputs drop to 0 asynchronously, no done, B unchanged, INIT sequence repeats.
- With CTRL_BACK_TO_BACK_EN, stream LDI 3 / ADDI B,A,2 / NOP with valid held high. Required: steps in 4 consecutive cycles, no idle cycle, B=5. Without the macro, one IDLE cycle between instructions.
